// File: rtl/regfile_pkg.sv
// Shared constants and state type for the register file write scheduler.
// Writing to ZERO_REG is accepted but never reaches the register file.
package regfile_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        CLEAR,
        RUN
    } sched_state_t;
endpackage

// File: rtl/regfile_write_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr and wraps modulo NUM_REQ; the first valid index wins.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   winner,
    output logic               found
);

    always_comb begin
        int idx;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Owns the register file write port: a zero-clear sweep after reset, then
// round-robin sharing among the writeback requesters with a registered write.
module regfile_write_sched #(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      regWrite,
    output logic [ADDR_W-1:0]         writeReg,
    output logic [DATA_W-1:0]         writeData,
    output logic                      init_done,
    output logic                      inflight_valid,
    output logic [ADDR_W-1:0]         inflight_addr
);
    import regfile_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t        state, state_next;
    logic [ADDR_W-1:0]   counter;
    logic [PTR_W-1:0]    ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    winner;
    logic                found;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                clear_last;
    logic                accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner),
        .found  (found)
    );

    assign win_addr   = req_addr[int'(winner)*ADDR_W +: ADDR_W];
    assign win_data   = req_data[int'(winner)*DATA_W +: DATA_W];
    assign clear_last = (counter == ADDR_W'(NUM_REGS - 1));
    assign accept     = (state == RUN) && found && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        case (state)
            CLEAR: begin
                if (clear_last) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!reset) begin
                    req_ready = grant;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // Address 0 is still granted and advances the pointer, but the write is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter   <= '0;
            ptr       <= '0;
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            init_done <= 1'b0;
        end else if (state == CLEAR) begin
            regWrite  <= 1'b1;
            writeReg  <= counter;
            writeData <= '0;
            counter   <= counter + ADDR_W'(1);
            if (clear_last) begin
                init_done <= 1'b1;
            end
        end else begin
            regWrite <= 1'b0;
            if (accept) begin
                ptr <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
                if (win_addr != ADDR_W'(ZERO_REG)) begin
                    regWrite  <= 1'b1;
                    writeReg  <= win_addr;
                    writeData <= win_data;
                end
            end
        end
    end

    assign inflight_valid = regWrite;
    assign inflight_addr  = writeReg;

endmodule

// File: tb/tb_regfile_write_sched.sv
// Randomized scoreboard bench for regfile_write_sched against a behavioural model
// of the clear sweep and round-robin write scheduling.
module tb_regfile_write_sched;

    localparam int NREQ = 3;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              regWrite;
    logic [4:0]        writeReg;
    logic [31:0]       writeData;
    logic              init_done;
    logic              inflight_valid;
    logic [4:0]        inflight_addr;

    regfile_write_sched #(
        .NUM_REQ  (NREQ),
        .ADDR_W   (5),
        .DATA_W   (32),
        .NUM_REGS (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .regWrite       (regWrite),
        .writeReg       (writeReg),
        .writeData      (writeData),
        .init_done      (init_done),
        .inflight_valid (inflight_valid),
        .inflight_addr  (inflight_addr)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        init;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   started  = 0;

    // Behavioural model of the scheduler as seen from outside
    bit          mClear;
    int          mCount;
    int          mPtr;
    bit          mInit;
    logic [4:0]  mLastAddr;
    logic [31:0] mLastData;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs at negedge, check ready, predict the next edge's outputs
    task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] v,
                                 input logic [NREQ*5-1:0] a, input logic [NREQ*32-1:0] d,
                                 output int win);
        logic [NREQ-1:0] expReady;
        logic [4:0]      wa;
        exp_t            e;
        @(negedge clk);
        reset     = rst;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        #1;
        win      = -1;
        expReady = '0;
        if (!rst && !mClear) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (mPtr + k) % NREQ;
                if (win < 0 && v[idx]) win = idx;
            end
            if (win >= 0) expReady[win] = 1'b1;
        end
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        if (rst) begin
            mClear = 1; mCount = 0; mPtr = 0; mInit = 0;
            mLastAddr = '0; mLastData = '0;
            e = '{wr: 1'b0, addr: 5'd0, data: 32'd0, init: 1'b0};
        end else if (mClear) begin
            mLastAddr = 5'(mCount);
            mLastData = '0;
            if (mCount == 31) begin
                mClear = 0;
                mInit  = 1;
            end
            mCount++;
            e = '{wr: 1'b1, addr: mLastAddr, data: mLastData, init: mInit};
        end else begin
            e.wr = 1'b0;
            if (win >= 0) begin
                mPtr = (win + 1) % NREQ;
                wa   = a[win*5 +: 5];
                if (wa != 5'd0) begin
                    e.wr      = 1'b1;
                    mLastAddr = wa;
                    mLastData = d[win*32 +: 32];
                end
            end
            e.addr = mLastAddr;
            e.data = mLastData;
            e.init = mInit;
        end
        sb.push_back(e);
        started = 1;
    endtask

    // Monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (sb.size() == 0) begin
                    checkOutput("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("regWrite", 32'(regWrite), 32'(e.wr));
                    checkOutput("writeReg", 32'(writeReg), 32'(e.addr));
                    checkOutput("writeData", writeData, e.data);
                    checkOutput("init_done", 32'(init_done), 32'(e.init));
                    checkOutput("inflight_valid", 32'(inflight_valid), 32'(e.wr));
                    checkOutput("inflight_addr", 32'(inflight_addr), 32'(e.addr));
                end
            end
        end
    end

    initial begin
        int                 w;
        logic [NREQ-1:0]    pv;
        logic [NREQ*5-1:0]  pa;
        logic [NREQ*32-1:0] pd;
        mClear = 1; mCount = 0; mPtr = 0; mInit = 0;
        mLastAddr = '0; mLastData = '0;
        reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;

        $display("[TB] reset and clear sweep");
        applyStimulus(1'b1, '0, '0, '0, w);
        applyStimulus(1'b1, '0, '0, '0, w);
        for (int i = 0; i < 35; i++) applyStimulus(1'b0, '0, '0, '0, w);

        $display("[TB] single write, zero register, contention, fairness");
        applyStimulus(1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF}, w);
        applyStimulus(1'b0, '0, '0, '0, w);
        applyStimulus(1'b0, 3'b100, {5'd0, 5'd0, 5'd0}, {32'hFFFFFFFF, 32'd0, 32'd0}, w);
        applyStimulus(1'b0, '0, '0, '0, w);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3333, 32'h2222, 32'h1111}, w);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 3'b110, {5'd9, 5'd8, 5'd0}, {32'h9999, 32'h8888, 32'd0}, w);
        applyStimulus(1'b0, '0, '0, '0, w);

        $display("[TB] reset mid-sweep");
        applyStimulus(1'b1, '0, '0, '0, w);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, '0, '0, w);
        applyStimulus(1'b1, '0, '0, '0, w);
        for (int i = 0; i < 34; i++) applyStimulus(1'b0, '0, '0, '0, w);

        $display("[TB] randomized traffic");
        pv = '0; pa = '0; pd = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i]) begin
                    pv[i]         = ($urandom_range(0, 2) != 0);
                    pa[i*5 +: 5]  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    pd[i*32 +: 32] = $urandom;
                end
            end
            applyStimulus(1'b0, pv, pa, pd, w);
            if (w >= 0) pv[w] = 1'b0;
        end

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 3'b111, pa, pd, w);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 3'b111, pa, pd, w);
        applyStimulus(1'b0, '0, '0, '0, w);

        @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
